// File: rtl/jpeg_ls_scan_if.sv
// Handshake/bus bundle between the pixel source and jpeg_ls_scan_ctrl.
// The master drives the raw raster stream. The slave returns the framed
// sample neighbourhood and status.
interface jpeg_ls_scan_if #(
  parameter int WIDTH = 16,
  parameter int CW    = 10
);
  logic             frame_start;
  logic             data_en;
  logic [WIDTH-1:0] pixel_data;
  logic             en;
  logic [WIDTH-1:0] Ix, Ra, Rb, Rc, Rd;
  logic [CW-1:0]    col, row;
  logic             sol, eol, eof;
  logic             busy;
  logic             frame_done;
  logic             err;

  modport master (
    output frame_start, data_en, pixel_data,
    input  en, Ix, Ra, Rb, Rc, Rd, col, row, sol, eol, eof, busy, frame_done, err
  );

  modport slave (
    input  frame_start, data_en, pixel_data,
    output en, Ix, Ra, Rb, Rc, Rd, col, row, sol, eol, eof, busy, frame_done, err
  );
endinterface

// File: rtl/jpeg_ls_scan_ctrl.sv
// JPEG-LS raster-scan sequencer. It tracks the sample position and keeps
// the previous row in a line buffer. It emits each sample with its causal
// neighbours Ra/Rb/Rc/Rd, with the image-edge substitutions applied, plus
// frame framing flags.
// Optional macro JPEG_LS_SCAN_ERR_EN: enables the sticky protocol-error flag.
// When it is undefined, err is tied low.
module jpeg_ls_scan_ctrl #(
  parameter int WIDTH = 16,
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int CW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  jpeg_ls_scan_if.slave bus
);
  localparam int            AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, row_q;           // position of the next sample
  logic [WIDTH-1:0] lbuf_q [IMG_W];         // row y-1 ahead of col, row y behind it
  logic [WIDTH-1:0] prev_pix_q;             // left neighbour for x>0
  logic [WIDTH-1:0] prev_rb_q;              // above of previous sample = above-left now
  logic [WIDTH-1:0] c0_q;                   // Rb seen at x=0 on the previous row

  logic             en_q, sol_q, eol_q, eof_q, busy_q, fd_q;
  logic [WIDTH-1:0] ix_q, ra_q, rb_q, rc_q, rd_q;
  logic [CW-1:0]    pcol_q, prow_q;

  logic             start, accept, first_col, last_col, top_row, last_pix;
  logic [CW-1:0]    cur_col, cur_row;
  logic [AW-1:0]    idx, idx_n;
  logic [WIDTH-1:0] rb_rd, rd_rd, rb, rc, rd, ra;

  // Acceptance, current position and neighbourhood selection
  always_comb begin
    start     = bus.frame_start && (state_q == IDLE);
    accept    = bus.data_en && ((state_q == ACTIVE) || start);
    cur_col   = start ? '0 : col_q;
    cur_row   = start ? '0 : row_q;
    first_col = (cur_col == '0);
    last_col  = (cur_col == LAST_COL);
    top_row   = (cur_row == '0);
    last_pix  = last_col && (cur_row == LAST_ROW);
    idx       = cur_col[AW-1:0];
    idx_n     = idx + AW'(1);
    rb_rd     = lbuf_q[idx];
    // Reading past the last column is masked by the Rd=Rb edge rule
    rd_rd     = last_col ? rb_rd : lbuf_q[idx_n];
    rb        = top_row ? '0 : rb_rd;
    rd        = top_row ? '0 : rd_rd;
    // buf[x-1] already holds this row's sample, so above-left comes from
    // the previous sample's above value instead
    rc        = top_row ? '0 : (first_col ? c0_q : prev_rb_q);
    ra        = first_col ? rb : prev_pix_q;
    state_d   = state_q;
    case (state_q)
      IDLE:    if (bus.frame_start) state_d = ACTIVE;
      ACTIVE:  if (accept && last_pix) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A sample taken together with frame_start can also be the last one
    if (accept && last_pix) state_d = DONE;
  end

  // FSM, position counters, neighbour history and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      prev_pix_q <= '0;
      prev_rb_q  <= '0;
      c0_q       <= '0;
      en_q       <= 1'b0;
      sol_q      <= 1'b0;
      eol_q      <= 1'b0;
      eof_q      <= 1'b0;
      busy_q     <= 1'b0;
      fd_q       <= 1'b0;
      ix_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      rc_q       <= '0;
      rd_q       <= '0;
      pcol_q     <= '0;
      prow_q     <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_q == ACTIVE);
      fd_q    <= (state_q == DONE);
      en_q    <= accept;
      if (start) begin
        col_q <= '0;
        row_q <= '0;
      end
      if (accept) begin
        col_q      <= last_col ? '0 : cur_col + CW'(1);
        row_q      <= last_col ? cur_row + CW'(1) : cur_row;
        prev_pix_q <= bus.pixel_data;
        prev_rb_q  <= rb;
        if (first_col) c0_q <= rb;
        ix_q   <= bus.pixel_data;
        ra_q   <= ra;
        rb_q   <= rb;
        rc_q   <= rc;
        rd_q   <= rd;
        pcol_q <= cur_col;
        prow_q <= cur_row;
        sol_q  <= first_col;
        eol_q  <= last_col;
        eof_q  <= last_pix;
      end
    end
  end

  // Line buffer write after the neighbourhood read; contents survive reset
  always_ff @(posedge clk) begin
    if (accept) lbuf_q[idx] <= bus.pixel_data;
  end

`ifdef JPEG_LS_SCAN_ERR_EN
  logic err_q;

  // Sticky protocol error: stray data in IDLE or a re-arm while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if ((bus.data_en && (state_q == IDLE) && !bus.frame_start) ||
             (bus.frame_start && (state_q != IDLE)))
      err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.en         = en_q;
  assign bus.Ix         = ix_q;
  assign bus.Ra         = ra_q;
  assign bus.Rb         = rb_q;
  assign bus.Rc         = rc_q;
  assign bus.Rd         = rd_q;
  assign bus.col        = pcol_q;
  assign bus.row        = prow_q;
  assign bus.sol        = sol_q;
  assign bus.eol        = eol_q;
  assign bus.eof        = eof_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = fd_q;
endmodule
